// File: rtl/tmds_decoder.sv
// ---------------------------------------------------------------------------
// tmds_decoder
//   Receive side of one HDMI/TMDS channel. Takes 10-bit words from an
//   external deserializer, asks for bit-slips until control tokens line up,
//   tracks word lock, and decodes data symbols / control tokens.
//
//   Ports
//     clk_pixel    : pixel clock, all logic on its rising edge
//     sys_rst_n    : synchronous active-low reset
//     tmds_in      : 10-bit TMDS word, bit 0 first on the wire
//     tmds_valid   : tmds_in carries a new word this cycle
//     bitslip      : 1-cycle request to shift deserializer alignment by 1 bit
//     locked       : word alignment established
//     data_out     : decoded pixel byte
//     control_out  : last decoded control value {c1,c0}
//     ve_out       : 1 = data_out carries a video-data symbol
//     valid_out    : data_out/control_out/ve_out updated this cycle
//
//   Optional build macro TMDS_DECODER_STATS_EN adds:
//     slip_count      : saturating count of bitslip pulses
//     lock_loss_count : saturating count of LOCKED -> SEARCH transitions
// ---------------------------------------------------------------------------
module tmds_decoder #(
    parameter int unsigned LOCK_TOKENS    = 4,
    parameter int unsigned SEARCH_WINDOW  = 2048,
    parameter int unsigned SLIP_WAIT      = 16,
    parameter int unsigned NO_TOKEN_LIMIT = 4096
) (
    input  logic       clk_pixel,
    input  logic       sys_rst_n,
    input  logic [9:0] tmds_in,
    input  logic       tmds_valid,
    output logic       bitslip,
    output logic       locked,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       valid_out
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [7:0] slip_count,
    output logic [7:0] lock_loss_count
`endif
);

    localparam int unsigned TOK_W = $clog2(LOCK_TOKENS) + 1;
    localparam int unsigned WIN_W = $clog2(SEARCH_WINDOW) + 1;
    localparam int unsigned SW_W  = $clog2(SLIP_WAIT) + 1;
    localparam int unsigned NT_W  = $clog2(NO_TOKEN_LIMIT) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [SW_W-1:0]  sw_cnt_q, sw_cnt_d;
    logic [NT_W-1:0]  nt_cnt_q, nt_cnt_d;
    logic             bitslip_q, bitslip_d;
    logic             locked_q, locked_d;

    logic [TOK_W-1:0] tok_inc;
    logic [WIN_W-1:0] win_inc;
    logic [SW_W-1:0]  sw_inc;
    logic [NT_W-1:0]  nt_inc;

    // Pipeline: stage 1 captures the word, stage 2 holds the decode,
    // output registers land two edges after acceptance.
    logic       s1_valid_q, s1_valid_d;
    logic [9:0] s1_word_q, s1_word_d;
    logic       s1_tok_q, s1_tok_d;
    logic [1:0] s1_ctrl_q, s1_ctrl_d;
    logic       s2_valid_q, s2_valid_d;
    logic       s2_tok_q, s2_tok_d;
    logic [1:0] s2_ctrl_q, s2_ctrl_d;
    logic [7:0] s2_data_q, s2_data_d;
    logic [7:0] data_q, data_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       ve_q, ve_d;
    logic       valid_out_q, valid_out_d;

`ifdef TMDS_DECODER_STATS_EN
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] loss_cnt_q, loss_cnt_d;
`endif

    logic       is_tok;
    logic [1:0] tok_val;
    logic [7:0] d_bar;
    logic [7:0] dec;

    // Exact-match control token detection on the incoming word.
    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (tmds_in)
            10'h354: tok_val = 2'b00;
            10'h0AB: tok_val = 2'b01;
            10'h154: tok_val = 2'b10;
            10'h2AB: tok_val = 2'b11;
            default: is_tok  = 1'b0;
        endcase
    end

    assign tok_inc = tok_cnt_q + TOK_W'(1);
    assign win_inc = win_cnt_q + WIN_W'(1);
    assign sw_inc  = sw_cnt_q + SW_W'(1);
    assign nt_inc  = nt_cnt_q + NT_W'(1);

    // Alignment FSM. Tokens are tested before the window/no-token limits so a
    // token arriving on the limit word cancels the slip or lock loss.
    always_comb begin
        state_d   = state_q;
        tok_cnt_d = tok_cnt_q;
        win_cnt_d = win_cnt_q;
        sw_cnt_d  = sw_cnt_q;
        nt_cnt_d  = nt_cnt_q;
        bitslip_d = 1'b0;
        locked_d  = locked_q;
`ifdef TMDS_DECODER_STATS_EN
        slip_cnt_d = slip_cnt_q;
        loss_cnt_d = loss_cnt_q;
`endif
        if (tmds_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_tok) begin
                        win_cnt_d = '0;
                        if (tok_inc == TOK_W'(LOCK_TOKENS)) begin
                            state_d   = ST_LOCKED;
                            locked_d  = 1'b1;
                            tok_cnt_d = '0;
                            nt_cnt_d  = '0;
                        end else begin
                            tok_cnt_d = tok_inc;
                        end
                    end else begin
                        tok_cnt_d = '0;
                        if (win_inc == WIN_W'(SEARCH_WINDOW)) begin
                            state_d   = ST_SLIP_WAIT;
                            bitslip_d = 1'b1;
                            win_cnt_d = '0;
                            sw_cnt_d  = '0;
`ifdef TMDS_DECODER_STATS_EN
                            if (slip_cnt_q != 8'hFF) slip_cnt_d = slip_cnt_q + 8'd1;
`endif
                        end else begin
                            win_cnt_d = win_inc;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    if (sw_inc == SW_W'(SLIP_WAIT)) begin
                        state_d   = ST_SEARCH;
                        sw_cnt_d  = '0;
                        tok_cnt_d = '0;
                        win_cnt_d = '0;
                    end else begin
                        sw_cnt_d = sw_inc;
                    end
                end
                ST_LOCKED: begin
                    if (is_tok) begin
                        nt_cnt_d = '0;
                    end else if (nt_inc == NT_W'(NO_TOKEN_LIMIT)) begin
                        state_d   = ST_SEARCH;
                        locked_d  = 1'b0;
                        nt_cnt_d  = '0;
                        tok_cnt_d = '0;
                        win_cnt_d = '0;
`ifdef TMDS_DECODER_STATS_EN
                        if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
`endif
                    end else begin
                        nt_cnt_d = nt_inc;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // Stage 1: qualify with the registered lock flag seen by this word.
    always_comb begin
        s1_valid_d = tmds_valid & locked_q;
        s1_word_d  = s1_word_q;
        s1_tok_d   = s1_tok_q;
        s1_ctrl_d  = s1_ctrl_q;
        if (tmds_valid) begin
            s1_word_d = tmds_in;
            s1_tok_d  = is_tok;
            s1_ctrl_d = tok_val;
        end
    end

    // Stage 2: transition-minimised byte recovery.
    always_comb begin
        d_bar  = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
        dec    = '0;
        dec[0] = d_bar[0];
        for (int unsigned i = 1; i < 8; i++) begin
            dec[i] = s1_word_q[8] ? (d_bar[i] ^ d_bar[i-1]) : ~(d_bar[i] ^ d_bar[i-1]);
        end
        s2_valid_d = s1_valid_q;
        s2_tok_d   = s1_tok_q;
        s2_ctrl_d  = s1_ctrl_q;
        s2_data_d  = dec;
    end

    // Output stage: control_out holds across data symbols.
    always_comb begin
        valid_out_d = s2_valid_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        ve_d        = ve_q;
        if (s2_valid_q) begin
            if (s2_tok_q) begin
                ve_d   = 1'b0;
                data_d = '0;
                ctrl_d = s2_ctrl_q;
            end else begin
                ve_d   = 1'b1;
                data_d = s2_data_q;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!sys_rst_n) begin
            state_q     <= ST_SEARCH;
            tok_cnt_q   <= '0;
            win_cnt_q   <= '0;
            sw_cnt_q    <= '0;
            nt_cnt_q    <= '0;
            bitslip_q   <= 1'b0;
            locked_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_tok_q    <= 1'b0;
            s1_ctrl_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_tok_q    <= 1'b0;
            s2_ctrl_q   <= '0;
            s2_data_q   <= '0;
            data_q      <= '0;
            ctrl_q      <= '0;
            ve_q        <= 1'b0;
            valid_out_q <= 1'b0;
`ifdef TMDS_DECODER_STATS_EN
            slip_cnt_q  <= '0;
            loss_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tok_cnt_q   <= tok_cnt_d;
            win_cnt_q   <= win_cnt_d;
            sw_cnt_q    <= sw_cnt_d;
            nt_cnt_q    <= nt_cnt_d;
            bitslip_q   <= bitslip_d;
            locked_q    <= locked_d;
            s1_valid_q  <= s1_valid_d;
            s1_word_q   <= s1_word_d;
            s1_tok_q    <= s1_tok_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s2_valid_q  <= s2_valid_d;
            s2_tok_q    <= s2_tok_d;
            s2_ctrl_q   <= s2_ctrl_d;
            s2_data_q   <= s2_data_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            ve_q        <= ve_d;
            valid_out_q <= valid_out_d;
`ifdef TMDS_DECODER_STATS_EN
            slip_cnt_q  <= slip_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
`endif
        end
    end

    assign bitslip     = bitslip_q;
    assign locked      = locked_q;
    assign data_out    = data_q;
    assign control_out = ctrl_q;
    assign ve_out      = ve_q;
    assign valid_out   = valid_out_q;
`ifdef TMDS_DECODER_STATS_EN
    assign slip_count      = slip_cnt_q;
    assign lock_loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_decoder
//   Directed plus randomized self-checking bench for tmds_decoder.
//   Define TMDS_DECODER_STATS_EN for both bench and RTL to cover the
//   statistics counters.
// ---------------------------------------------------------------------------
module tb_tmds_decoder;

    localparam int unsigned SEARCH_WINDOW  = 2048;
    localparam int unsigned SLIP_WAIT      = 16;
    localparam int unsigned NO_TOKEN_LIMIT = 4096;
    localparam int unsigned LINE_WORDS     = 1650;
    localparam int unsigned ACTIVE_WORDS   = 1280;

    logic       clk_pixel = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [9:0] tmds_in = '0;
    logic       tmds_valid = 1'b0;
    logic       bitslip;
    logic       locked;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       valid_out;
`ifdef TMDS_DECODER_STATS_EN
    logic [7:0] slip_count;
    logic [7:0] lock_loss_count;
`endif

    int checks = 0;
    int failures = 0;

    tmds_decoder #(
        .LOCK_TOKENS   (4),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .SLIP_WAIT     (SLIP_WAIT),
        .NO_TOKEN_LIMIT(NO_TOKEN_LIMIT)
    ) dut (
        .clk_pixel      (clk_pixel),
        .sys_rst_n      (sys_rst_n),
        .tmds_in        (tmds_in),
        .tmds_valid     (tmds_valid),
        .bitslip        (bitslip),
        .locked         (locked),
        .data_out       (data_out),
        .control_out    (control_out),
        .ve_out         (ve_out),
        .valid_out      (valid_out)
`ifdef TMDS_DECODER_STATS_EN
        ,
        .slip_count     (slip_count),
        .lock_loss_count(lock_loss_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] w);
        tmds_valid = v;
        tmds_in    = w;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bitslip"}, bitslip, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_ctrl"}, control_out, 0);
        chk({tag, "_ve"}, ve_out, 0);
        chk({tag, "_valid"}, valid_out, 0);
`ifdef TMDS_DECODER_STATS_EN
        chk({tag, "_slipcnt"}, slip_count, 0);
        chk({tag, "_losscnt"}, lock_loss_count, 0);
`endif
    endtask

    task automatic reset_dut(input string tag);
        sys_rst_n = 1'b0;
        drive(1'b0, 10'h000);
        chk_zero(tag);
        sys_rst_n = 1'b1;
    endtask

    // Reference decode: d ^ (d << 1) gives the XOR chain with bit 0 = d[0];
    // the XNOR variant flips bits 7..1.
    function automatic logic [7:0] ref_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] x;
        d = q[9] ? ~q[7:0] : q[7:0];
        x = d ^ (d << 1);
        return q[8] ? x : (x ^ 8'hFE);
    endfunction

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    // 720p-like symbol stream: active pixels, then blanking tokens.
    function automatic logic [9:0] sym(input int unsigned n);
        return ((n % LINE_WORDS) < ACTIVE_WORDS) ? 10'h100 : 10'h354;
    endfunction

    // Word seen by a deserializer whose boundary is k bits late.
    function automatic logic [9:0] stream_word(input int unsigned n, input int unsigned k);
        logic [19:0] pair;
        pair = {sym(n + 1), sym(n)};
        return pair[k +: 10];
    endfunction

    initial begin
        logic [9:0] toks [4];
        logic       pv1, pv2, v;
        logic [9:0] pw1, pw2, w;
        logic [7:0] exp_data;
        logic [1:0] exp_ctrl;
        logic       exp_ve;
        logic       bs_seen, vo_seen, prev_bs;
        int         tc, pulses, since, kofs;
        int unsigned n;

        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

        // Reset state
        sys_rst_n = 1'b0;
        drive(1'b0, 10'h000);
        drive(1'b0, 10'h000);
        chk_zero("reset");
        sys_rst_n = 1'b1;

        // Lock on 4 tokens; nothing flows out until a post-lock word
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'h354);
            chk("lock_seq_locked", locked, (i == 3) ? 1 : 0);
            chk("lock_seq_valid", valid_out, 0);
        end
        drive(1'b1, 10'h0AB);
        chk("tok_n0_valid", valid_out, 0);
        drive(1'b0, 10'h000);
        chk("tok_n1_valid", valid_out, 0);
        drive(1'b0, 10'h000);
        chk("tok_valid", valid_out, 1);
        chk("tok_ve", ve_out, 0);
        chk("tok_ctrl", control_out, 2'b01);
        chk("tok_data", data_out, 0);
        drive(1'b0, 10'h000);
        chk("tok_hold_valid", valid_out, 0);
        chk("tok_hold_ctrl", control_out, 2'b01);

        // Two data symbols back to back
        drive(1'b1, 10'h100);
        drive(1'b1, 10'h2FF);
        drive(1'b0, 10'h000);
        chk("d100_valid", valid_out, 1);
        chk("d100_data", data_out, 8'h00);
        chk("d100_ve", ve_out, 1);
        chk("d100_ctrl", control_out, 2'b01);
        drive(1'b0, 10'h000);
        chk("d2ff_valid", valid_out, 1);
        chk("d2ff_data", data_out, 8'hFE);
        chk("d2ff_ve", ve_out, 1);
        chk("d2ff_ctrl", control_out, 2'b01);
        drive(1'b0, 10'h000);
        chk("d2ff_hold_valid", valid_out, 0);
        chk("d2ff_hold_data", data_out, 8'hFE);

        // Random words while locked against the reference decode
        pv1 = 1'b0; pv2 = 1'b0; pw1 = '0; pw2 = '0;
        exp_data = 8'hFE; exp_ctrl = 2'b01; exp_ve = 1'b1;
        for (int t = 0; t < 400; t++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) w = toks[$urandom_range(0, 3)];
            else w = 10'($urandom_range(0, 1023));
            drive(v, w);
            if (pv2) begin
                tc = tok_code(pw2);
                if (tc >= 0) begin
                    exp_ve = 1'b0; exp_data = 8'h00; exp_ctrl = 2'(tc);
                end else begin
                    exp_ve = 1'b1; exp_data = ref_decode(pw2);
                end
            end
            chk("rnd_valid", valid_out, pv2);
            chk("rnd_data", data_out, exp_data);
            chk("rnd_ctrl", control_out, exp_ctrl);
            chk("rnd_ve", ve_out, exp_ve);
            chk("rnd_locked", locked, 1);
            pv2 = pv1; pw2 = pw1; pv1 = v; pw1 = w;
        end
        drive(1'b0, 10'h000);
        drive(1'b0, 10'h000);

        // Lock loss after NO_TOKEN_LIMIT data words, no slip
        drive(1'b1, 10'h354);
        bs_seen = 1'b0;
        for (int i = 1; i <= int'(NO_TOKEN_LIMIT); i++) begin
            drive(1'b1, 10'h100);
            bs_seen |= bitslip;
            if (i == int'(NO_TOKEN_LIMIT) - 1) chk("nt_before_locked", locked, 1);
        end
        chk("nt_loss_locked", locked, 0);
        chk("nt_loss_bitslip", bitslip, 0);
        drive(1'b1, 10'h100);
        bs_seen |= bitslip;
        chk("nt_after_locked", locked, 0);
        chk("nt_no_slip", bs_seen, 0);
`ifdef TMDS_DECODER_STATS_EN
        chk("nt_losscnt", lock_loss_count, 1);
`endif

        // Token on the limit word keeps lock
        for (int i = 0; i < 4; i++) drive(1'b1, 10'h354);
        chk("relock", locked, 1);
        for (int i = 1; i < int'(NO_TOKEN_LIMIT); i++) drive(1'b1, 10'h100);
        drive(1'b1, 10'h354);
        chk("nt_tok_wins", locked, 1);
        for (int i = 0; i < 10; i++) drive(1'b1, 10'h100);
        chk("nt_tok_cleared", locked, 1);

        // tmds_valid toggling during SEARCH
        reset_dut("rst_toggle");
        for (int i = 0; i < 8; i++) begin
            drive((i % 2) == 0, 10'h354);
            chk("tgl_locked", locked, (i >= 6) ? 1 : 0);
            chk("tgl_valid", valid_out, 0);
        end
        drive(1'b0, 10'h354);
        chk("tgl_idle_valid", valid_out, 0);
        drive(1'b1, 10'h2FF);
        chk("tgl_idle2_valid", valid_out, 0);
        drive(1'b0, 10'h354);
        chk("tgl_gap_valid", valid_out, 0);
        drive(1'b0, 10'h354);
        chk("tgl_word_valid", valid_out, 1);
        chk("tgl_word_data", data_out, 8'hFE);
        chk("tgl_word_ve", ve_out, 1);

        // Reset during LOCKED aborts lock and in-flight words
        drive(1'b1, 10'h0AB);
        sys_rst_n = 1'b0;
        drive(1'b1, 10'h154);
        chk_zero("rst_locked");
        sys_rst_n = 1'b1;
        drive(1'b0, 10'h000);
        chk("rst_locked_flush1", valid_out, 0);
        drive(1'b0, 10'h000);
        chk("rst_locked_flush2", valid_out, 0);
        chk("rst_locked_ctrl", control_out, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'h354);
            chk("rst_locked_relock", locked, (i == 3) ? 1 : 0);
        end

        // Reset during SLIP_WAIT
        reset_dut("rst_pre_slip");
        for (int i = 1; i <= int'(SEARCH_WINDOW); i++) begin
            drive(1'b1, 10'h100);
            if (i == int'(SEARCH_WINDOW) - 1) chk("win_before_slip", bitslip, 0);
        end
        chk("win_slip", bitslip, 1);
        drive(1'b1, 10'h100);
        chk("win_slip_width", bitslip, 0);
        drive(1'b1, 10'h100);
        drive(1'b1, 10'h100);
`ifdef TMDS_DECODER_STATS_EN
        chk("win_slipcnt", slip_count, 1);
`endif
        sys_rst_n = 1'b0;
        drive(1'b1, 10'h354);
        chk_zero("rst_slipwait");
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'h354);
            chk("rst_slipwait_lock", locked, (i == 3) ? 1 : 0);
        end

        // Misaligned 720p-like stream: deserializer 3 bits late
        reset_dut("rst_stream");
        n = $urandom_range(0, LINE_WORDS - 1);
        kofs = 3; pulses = 0; since = 0; prev_bs = 1'b0; vo_seen = 1'b0;
        for (int c = 0; c < 15000; c++) begin
            v = ($urandom_range(0, 7) != 0);
            w = v ? stream_word(n, kofs) : 10'($urandom_range(0, 1023));
            drive(v, w);
            if (v) begin
                n++;
                since++;
            end
            vo_seen |= valid_out;
            if (prev_bs) chk("stream_slip_width", bitslip, 0);
            if (bitslip) begin
                pulses++;
                chk("stream_slip_spacing",
                    since >= ((pulses == 1) ? int'(SEARCH_WINDOW) : int'(SEARCH_WINDOW + SLIP_WAIT)), 1);
                since = 0;
                if (kofs > 0) kofs--;
            end
            prev_bs = bitslip;
            if (locked) break;
        end
        chk("stream_locked", locked, 1);
        chk("stream_pulses", pulses, 3);
        chk("stream_aligned", kofs, 0);
        chk("stream_no_valid_out", vo_seen, 0);
`ifdef TMDS_DECODER_STATS_EN
        chk("stream_slipcnt", slip_count, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
